// File: rtl/hazard_forward_unit_if.sv
// Decode-stage hazard interface: decode (master) presents its operand/destination
// info and the hazard unit (slave) answers with forward selects, stall and WB write port.
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_ra;
  logic [REG_ADDR_W-1:0] id_rb;
  logic                  id_use_a;
  logic                  id_use_b;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_is_load;
  logic                  flush;
  logic [1:0]            ForwardA;
  logic [1:0]            ForwardB;
  logic                  stall;
  logic                  WB_signals;
  logic [REG_ADDR_W-1:0] DestinationRegister;

  modport master (
    output id_valid, id_ra, id_rb, id_use_a, id_use_b,
           id_reg_write, id_rd, id_is_load, flush,
    input  ForwardA, ForwardB, stall, WB_signals, DestinationRegister
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_use_a, id_use_b,
           id_reg_write, id_rd, id_is_load, flush,
    output ForwardA, ForwardB, stall, WB_signals, DestinationRegister
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit shadowing the EX/MEM/WB destination tags for decode.
// HAZARD_FWD_EN defined: bypass selects plus load-use stall; undefined: stall-until-retire.
module hazard_forward_unit #(
  parameter int REG_ADDR_W  = 3,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_forward_unit_if.slave hz
);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     wr;
    reg_idx_t rd;
    logic     ld;
  } slot_t;

  localparam logic ZERO_EN = (ZERO_REG_EN != 0);

  slot_t slot_ex;
  slot_t slot_mem;
  slot_t slot_wb;
  slot_t ex_next;

  logic  stall;
  logic  rd_a;
  logic  rd_b;
  logic  a_ex, a_mem, a_wb;
  logic  b_ex, b_mem, b_wb;
  logic  unused_ld;

  function automatic logic match(input slot_t s, input reg_idx_t r);
    return s.wr && (s.rd == r) && !(ZERO_EN && (r == '0));
  endfunction

  assign a_ex  = match(slot_ex,  hz.id_ra);
  assign a_mem = match(slot_mem, hz.id_ra);
  assign a_wb  = match(slot_wb,  hz.id_ra);
  assign b_ex  = match(slot_ex,  hz.id_rb);
  assign b_mem = match(slot_mem, hz.id_rb);
  assign b_wb  = match(slot_wb,  hz.id_rb);

  assign rd_a = hz.id_valid & hz.id_use_a;
  assign rd_b = hz.id_valid & hz.id_use_b;

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic en, input logic m_ex,
                                         input logic m_mem, input logic m_wb);
    if (!en)   return 2'd0;
    if (m_ex)  return 2'd1;
    if (m_mem) return 2'd2;
    if (m_wb)  return 2'd3;
    return 2'd0;
  endfunction

  assign hz.ForwardA = fwd_sel(rd_a, a_ex, a_mem, a_wb);
  assign hz.ForwardB = fwd_sel(rd_b, b_ex, b_mem, b_wb);

  // Only a load still in EX cannot be bypassed; one bubble moves it to MEM.
  assign stall = hz.id_valid & ~hz.flush & slot_ex.ld &
                 ((hz.id_use_a & a_ex) | (hz.id_use_b & b_ex));

  assign unused_ld = ^{slot_mem.ld, slot_wb.ld};
`else
  assign hz.ForwardA = 2'd0;
  assign hz.ForwardB = 2'd0;

  // No bypass: hold decode until every matching producer has left WB.
  assign stall = hz.id_valid & ~hz.flush &
                 ((hz.id_use_a & (a_ex | a_mem | a_wb)) |
                  (hz.id_use_b & (b_ex | b_mem | b_wb)));

  assign unused_ld = ^{slot_ex.ld, slot_mem.ld, slot_wb.ld};
`endif

  assign hz.stall               = stall;
  assign hz.WB_signals          = slot_wb.wr;
  assign hz.DestinationRegister = slot_wb.rd;

  always_comb begin
    ex_next = '0;
    if (hz.id_valid && !stall && !hz.flush) begin
      ex_next.wr = hz.id_reg_write;
      ex_next.rd = hz.id_rd;
      ex_next.ld = hz.id_is_load;
    end
  end

  // The shadow pipe never halts; stall/flush only decide what enters EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_ex  <= '0;
      slot_mem <= '0;
      slot_wb  <= '0;
    end else begin
      slot_wb  <= slot_mem;
      slot_mem <= slot_ex;
      slot_ex  <= ex_next;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; covers both HAZARD_FWD_EN builds.
module tb_hazard_forward_unit;
  logic clk;
  logic reset_n;
  int   vec;
  int   miscompares;

  hazard_forward_unit_if #(.REG_ADDR_W(3)) hz ();

  hazard_forward_unit #(.REG_ADDR_W(3), .ZERO_REG_EN(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ua, input logic ub, input logic rw,
                       input logic [2:0] rd, input logic ld, input logic fl);
    hz.id_valid = v; hz.id_ra = ra; hz.id_rb = rb; hz.id_use_a = ua; hz.id_use_b = ub;
    hz.id_reg_write = rw; hz.id_rd = rd; hz.id_is_load = ld; hz.flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
    idle(); #1;
    vec++; if (hz.WB_signals !== 1'b1) begin miscompares++; $display("FAIL rst_pre_wbsig got %0b exp 1", hz.WB_signals); end
    vec++; if (hz.DestinationRegister !== 3'd1) begin miscompares++; $display("FAIL rst_pre_dest got %0d exp 1", hz.DestinationRegister); end
    drive(1, 3, 2, 1, 1, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    vec++; if (hz.WB_signals !== 1'b0) begin miscompares++; $display("FAIL rst_wbsig got %0b exp 0", hz.WB_signals); end
    vec++; if (hz.DestinationRegister !== 3'd0) begin miscompares++; $display("FAIL rst_dest got %0d exp 0", hz.DestinationRegister); end
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0b exp 0", hz.stall); end
    vec++; if (hz.ForwardA !== 2'd0 || hz.ForwardB !== 2'd0) begin miscompares++; $display("FAIL rst_fwd got %0d/%0d exp 0/0", hz.ForwardA, hz.ForwardB); end
    idle();
    #1 reset_n = 1'b1;
    repeat (3) cycle();
    #1;
    vec++; if (hz.WB_signals !== 1'b0) begin miscompares++; $display("FAIL rst_post_wbsig got %0b exp 0", hz.WB_signals); end
    vec++; if (hz.DestinationRegister !== 3'd0) begin miscompares++; $display("FAIL rst_post_dest got %0d exp 0", hz.DestinationRegister); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0); cycle();
    drive(1, 0, 5, 0, 1, 1, 7, 0, 0); #1;
    vec++; if (hz.stall !== 1'b1) begin miscompares++; $display("FAIL flush_pre_stall got %0b exp 1", hz.stall); end
    hz.flush = 1'b1; #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %0b exp 0", hz.stall); end
    cycle();
    idle(); cycle();
    #1;
    vec++; if (hz.WB_signals !== 1'b1 || hz.DestinationRegister !== 3'd5) begin miscompares++; $display("FAIL flush_load_retire got %0b/%0d exp 1/5", hz.WB_signals, hz.DestinationRegister); end
    cycle(); #1;
    vec++; if (hz.WB_signals !== 1'b0) begin miscompares++; $display("FAIL flush_slot_wbsig got %0b exp 0", hz.WB_signals); end
    drain();
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_ex_forward();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0); #1;
      vec++; if (hz.ForwardA !== exp_sel[k]) begin miscompares++; $display("FAIL exfwd_sel%0d got %0d exp %0d", k, hz.ForwardA, exp_sel[k]); end
      vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL exfwd_stall%0d got %0b exp 0", k, hz.stall); end
      cycle();
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0); cycle();
    drive(1, 0, 2, 0, 1, 0, 0, 0, 0); #1;
    vec++; if (hz.stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0b exp 1", hz.stall); end
    vec++; if (hz.ForwardB !== 2'd1) begin miscompares++; $display("FAIL lu_selb_stall got %0d exp 1", hz.ForwardB); end
    cycle(); #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_next got %0b exp 0", hz.stall); end
    vec++; if (hz.ForwardB !== 2'd2) begin miscompares++; $display("FAIL lu_selb_next got %0d exp 2", hz.ForwardB); end
    drain();
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0); cycle();
    drive(1, 4, 4, 1, 1, 0, 0, 0, 0); #1;
    vec++; if (hz.ForwardA !== 2'd1) begin miscompares++; $display("FAIL prio_sela got %0d exp 1", hz.ForwardA); end
    vec++; if (hz.ForwardB !== 2'd1) begin miscompares++; $display("FAIL prio_selb got %0d exp 1", hz.ForwardB); end
    drain();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0); cycle();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0); #1;
    vec++; if (hz.ForwardA !== 2'd0) begin miscompares++; $display("FAIL zero_sela got %0d exp 0", hz.ForwardA); end
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL zero_stall got %0b exp 0", hz.stall); end
    drain();
  endtask
`else
  task automatic test_stall_retire();
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0); cycle();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 6, 0, 1, 0, 1, 4, 0, 0); #1;
      vec++; if (hz.stall !== 1'b1) begin miscompares++; $display("FAIL sr_stall%0d got %0b exp 1", k, hz.stall); end
      vec++; if (hz.ForwardA !== 2'd0 || hz.ForwardB !== 2'd0) begin miscompares++; $display("FAIL sr_fwd%0d got %0d/%0d exp 0/0", k, hz.ForwardA, hz.ForwardB); end
      vec++; if (hz.WB_signals !== (k == 3)) begin miscompares++; $display("FAIL sr_wbsig%0d got %0b exp %0b", k, hz.WB_signals, (k == 3)); end
      if (k == 3) begin
        vec++; if (hz.DestinationRegister !== 3'd6) begin miscompares++; $display("FAIL sr_dest got %0d exp 6", hz.DestinationRegister); end
      end
      cycle();
    end
    #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL sr_release got %0b exp 0", hz.stall); end
    vec++; if (hz.WB_signals !== 1'b0) begin miscompares++; $display("FAIL sr_bubble_wb got %0b exp 0", hz.WB_signals); end
    cycle();
    idle(); cycle(); #1;
    vec++; if (hz.WB_signals !== 1'b0) begin miscompares++; $display("FAIL sr_bubble_wb2 got %0b exp 0", hz.WB_signals); end
    cycle(); #1;
    vec++; if (hz.WB_signals !== 1'b1 || hz.DestinationRegister !== 3'd4) begin miscompares++; $display("FAIL sr_consumer_wb got %0b/%0d exp 1/4", hz.WB_signals, hz.DestinationRegister); end
    drain();
  endtask

  task automatic test_sources();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); cycle();
    drive(1, 1, 5, 1, 0, 0, 0, 0, 0); #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL src_unused_b got %0b exp 0", hz.stall); end
    hz.id_use_b = 1'b1; #1;
    vec++; if (hz.stall !== 1'b1) begin miscompares++; $display("FAIL src_used_b got %0b exp 1", hz.stall); end
    hz.id_valid = 1'b0; #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL src_invalid got %0b exp 0", hz.stall); end
    drive(1, 0, 0, 0, 0, 0, 3, 0, 0); cycle();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0); #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL src_nowrite got %0b exp 0", hz.stall); end
    hz.id_ra = 3'd5; #1;
    vec++; if (hz.stall !== 1'b1) begin miscompares++; $display("FAIL src_mem_match got %0b exp 1", hz.stall); end
    drain();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0); #1;
    vec++; if (hz.stall !== 1'b0) begin miscompares++; $display("FAIL src_zero got %0b exp 0", hz.stall); end
    drain();
  endtask
`endif

  initial begin
    vec = 0;
    miscompares = 0;
    reset_n = 1'b0;
    idle();
    #12 reset_n = 1'b1;
    cycle();
    test_reset();
    test_flush();
`ifdef HAZARD_FWD_EN
    test_ex_forward();
    test_load_use();
    test_priority();
`else
    test_stall_retire();
    test_sources();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end
endmodule
